ai_target_select: RTL

//  Downstream stage of the ai density engine. Takes the 10x10 per-cell hit-density map it produces,

---
 rtl/battlechip_ai_pkg.sv | 10 +
 rtl/ai_group_max.sv | 25 ++
 rtl/ai_target_select.sv | 123 ++++++++++++
 3 files changed

// File: rtl/battlechip_ai_pkg.sv
// battlechip_ai_pkg: shared board constants, cell/coord/density types and pick FSM states
package battlechip_ai_pkg;
  localparam int BOARD_DIM = 10;
  localparam int NUM_CELLS = BOARD_DIM * BOARD_DIM;
  localparam int DENS_W = 6;
  typedef logic [6:0] cell_idx_t;
  typedef logic [3:0] coord_t;
  typedef logic [DENS_W-1:0] dens_t;
  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;
endpackage

// File: rtl/ai_group_max.sv
// ai_group_max: best unfired cell of a small group, ties to the lowest offset
module ai_group_max
  import battlechip_ai_pkg::*;
#(
  parameter int N = 1,
  parameter int OW = 1
) (
  input  logic [N-1:0][DENS_W-1:0] dens,
  input  logic [N-1:0]             fired,
  output logic                     has,
  output logic [OW-1:0]            off,
  output dens_t                    best
);
  always_comb begin
    has = 1'b0;
    off = '0;
    best = '0;
    for (int i = 0; i < N; i++)
      if (!fired[i] && (!has || dens[i] > best)) begin
        has = 1'b1;
        off = OW'(i);
        best = dens[i];
      end
  end
endmodule

// File: rtl/ai_target_select.sv
// ai_target_select: sequential argmax of density over unfired cells, result on valid/ready
module ai_target_select
  import battlechip_ai_pkg::*;
#(
  parameter int CELLS_PER_CYCLE = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [NUM_CELLS-1:0][DENS_W-1:0] density,
  input  logic [NUM_CELLS-1:0]             fired,
  output logic                             busy,
  output logic                             target_valid,
  input  logic                             target_ready,
  output cell_idx_t                        target_idx,
  output coord_t                           target_x,
  output coord_t                           target_y,
  output dens_t                            target_dens,
  output logic                             no_target
);
  localparam int G = NUM_CELLS / CELLS_PER_CYCLE;
  localparam int OW = CELLS_PER_CYCLE > 1 ? $clog2(CELLS_PER_CYCLE) : 1;
  state_t state_q, state_d;
  logic [NUM_CELLS-1:0][DENS_W-1:0] dens_q, dens_d;
  logic [NUM_CELLS-1:0] fired_q, fired_d;
  cell_idx_t cnt_q, cnt_d, best_idx_q, best_idx_d, idx_q, idx_d, base;
  dens_t best_dens_q, best_dens_d, tdens_q, tdens_d, g_dens;
  logic has_q, has_d, pend_q, pend_d, busy_q, busy_d, valid_q, valid_d, none_q, none_d, g_has;
  logic [OW-1:0] g_off;
  assign base = cell_idx_t'(cnt_q * CELLS_PER_CYCLE);
  ai_group_max #(.N(CELLS_PER_CYCLE), .OW(OW)) u_gm (
    .dens (dens_q[base +: CELLS_PER_CYCLE]),
    .fired(fired_q[base +: CELLS_PER_CYCLE]),
    .has  (g_has),
    .off  (g_off),
    .best (g_dens)
  );
  always_comb begin
    state_d = state_q;
    dens_d = dens_q;
    fired_d = fired_q;
    cnt_d = cnt_q;
    has_d = has_q;
    best_idx_d = best_idx_q;
    best_dens_d = best_dens_q;
    pend_d = pend_q;
    busy_d = busy_q;
    valid_d = valid_q;
    idx_d = idx_q;
    tdens_d = tdens_q;
    none_d = none_q;
    if (state_q == IDLE && start) begin
      state_d = SCAN;
      dens_d = density;
      fired_d = fired;
      cnt_d = '0;
      has_d = 1'b0;
      best_idx_d = '0;
      best_dens_d = '0;
      busy_d = 1'b1;
    end else if (state_q == SCAN) begin
      if (g_has && (!has_q || g_dens > best_dens_q)) begin
        has_d = 1'b1;
        best_idx_d = base + cell_idx_t'(g_off);
        best_dens_d = g_dens;
      end
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == cell_idx_t'(G - 1)) begin
        cnt_d = '0;
        state_d = HOLD;
        pend_d = 1'b1;
      end
    end else if (state_q == HOLD) begin
      if (pend_q) begin
        pend_d = 1'b0;
        valid_d = 1'b1;
        idx_d = best_idx_q;
        tdens_d = best_dens_q;
        none_d = !has_q;
      end else if (valid_q && target_ready) begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d = 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    dens_q <= dens_d;
    fired_q <= fired_d;
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      has_q <= 1'b0;
      best_idx_q <= '0;
      best_dens_q <= '0;
      pend_q <= 1'b0;
      busy_q <= 1'b0;
      valid_q <= 1'b0;
      idx_q <= '0;
      tdens_q <= '0;
      none_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      has_q <= has_d;
      best_idx_q <= best_idx_d;
      best_dens_q <= best_dens_d;
      pend_q <= pend_d;
      busy_q <= busy_d;
      valid_q <= valid_d;
      idx_q <= idx_d;
      tdens_q <= tdens_d;
      none_q <= none_d;
    end
  end
  assign busy = busy_q;
  assign target_valid = valid_q;
  assign target_idx = idx_q;
  assign target_dens = tdens_q;
  assign no_target = none_q;
  assign target_x = coord_t'(idx_q % BOARD_DIM);
  assign target_y = coord_t'(idx_q / BOARD_DIM);
endmodule
